// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e        : sequencer state encoding (RUN / MDU_WAIT)
//   REG_ADDR_W_DEF : default register index width
//   CTRL_ZERO      : all-zero decode control bundle driven when a bubble
//                    is inserted into ID/EX
//   bubbleMux      : helper that selects between live control and a bubble
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [7:0] CTRL_ZERO = 8'h00;

  // The decode stage feeds its control bundle through this when Control_sel
  // is high, so a stalled or flushed slot carries no side effects into EX.
  function automatic logic [7:0] bubbleMux(input logic sel, input logic [7:0] ctrl);
    return sel ? CTRL_ZERO : ctrl;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Groups the hazard inputs, MDU handshake and pipeline enable/flush outputs
// of pipeline_ctrl.
//   slave  modport : seen by pipeline_ctrl (hazard info in, enables out)
//   master modport : seen by the surrounding pipeline / testbench
// Optional macro PIPE_PERF_CNT_EN adds Stall_cycles and Flush_count.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W_DEF
);

  logic [REG_ADDR_W-1:0] RS1_ID;
  logic [REG_ADDR_W-1:0] RS2_ID;
  logic [REG_ADDR_W-1:0] RD_EX;
  logic                  MemRead_EX;
  logic                  Branch_taken_EX;
  logic                  Mdu_op_ID;
  logic                  Mdu_done;

  logic                  PC_write;
  logic                  IF_ID_Write;
  logic                  Control_sel;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Flush;
  logic                  Mdu_start;
  logic                  Mdu_abort;
  logic                  Mdu_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0]           Stall_cycles;
  logic [31:0]           Flush_count;

  modport slave (
    input  RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, Mdu_op_ID, Mdu_done,
    output PC_write, IF_ID_Write, Control_sel, IF_ID_Flush, ID_EX_Flush,
           Mdu_start, Mdu_abort, Mdu_timeout, Stall_cycles, Flush_count
  );

  modport master (
    output RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, Mdu_op_ID, Mdu_done,
    input  PC_write, IF_ID_Write, Control_sel, IF_ID_Flush, ID_EX_Flush,
           Mdu_start, Mdu_abort, Mdu_timeout, Stall_cycles, Flush_count
  );
`else
  modport slave (
    input  RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, Mdu_op_ID, Mdu_done,
    output PC_write, IF_ID_Write, Control_sel, IF_ID_Flush, ID_EX_Flush,
           Mdu_start, Mdu_abort, Mdu_timeout
  );

  modport master (
    output RS1_ID, RS2_ID, RD_EX, MemRead_EX, Branch_taken_EX, Mdu_op_ID, Mdu_done,
    input  PC_write, IF_ID_Write, Control_sel, IF_ID_Flush, ID_EX_Flush,
           Mdu_start, Mdu_abort, Mdu_timeout
  );
`endif

endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Combinational load-use detector: the instruction in EX is a load whose
// destination is read by the instruction in decode.
//   rs1_i, rs2_i : decode source registers
//   rd_i         : EX-stage destination register
//   memRead_i    : EX-stage instruction is a load
//   loadUse_o    : decode must stall one cycle
// ---------------------------------------------------------------------------
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  memRead_i,
  output logic                  loadUse_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  always_comb begin
    loadUse_o = memRead_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Arbitrates, in priority
// order, a taken branch, a load-use hazard and a multi-cycle MDU operation,
// and runs the MDU start/wait handshake with a watchdog.
//   clk   : pipeline clock
//   reset : asynchronous, active-low reset
//   bus   : pipeline_ctrl_if.slave (hazard inputs, MDU handshake, enables,
//           flush strobes, watchdog flag)
// Parameters: REG_ADDR_W, MDU_TIMEOUT (max wait cycles, >=2), CNT_W
// (watchdog width, must hold MDU_TIMEOUT).
// Optional macro PIPE_PERF_CNT_EN adds saturating Stall_cycles/Flush_count.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MDU_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             startQ, startD;
  logic             abortQ, abortD;
  logic             timeoutQ, timeoutD;

  logic             loadUse;
  logic             pcWrite;
  logic             ifIdWrite;
  logic             controlSel;
  logic             ifIdFlush;
  logic             idExFlush;

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) uHazard (
    .rs1_i     (bus.RS1_ID),
    .rs2_i     (bus.RS2_ID),
    .rd_i      (bus.RD_EX),
    .memRead_i (bus.MemRead_EX),
    .loadUse_o (loadUse)
  );

  // Next-state and pipeline-control decode. In RUN the sources are taken in
  // fixed priority (branch, load-use, MDU). In MDU_WAIT the front end is
  // frozen until the MDU finishes, an older branch kills it, or the watchdog
  // expires. While reset is held the enables show the idle RUN values so the
  // front end is not frozen by stale hazard inputs.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    startD     = 1'b0;
    abortD     = 1'b0;
    timeoutD   = timeoutQ;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    controlSel = 1'b0;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;

    case (stateQ)
      RUN: begin
        cntD = '0;
        if (bus.Branch_taken_EX) begin
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
          controlSel = 1'b1;
        end else if (loadUse) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          controlSel = 1'b1;
        end else if (bus.Mdu_op_ID) begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          controlSel = 1'b1;
          startD     = 1'b1;
          stateD     = MDU_WAIT;
        end
      end

      MDU_WAIT: begin
        pcWrite    = 1'b0;
        ifIdWrite  = 1'b0;
        controlSel = 1'b1;
        cntD       = cntQ + CNT_W'(1);
        if (bus.Branch_taken_EX) begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
          pcWrite   = 1'b1;
          ifIdWrite = 1'b1;
          abortD    = 1'b1;
          stateD    = RUN;
        end else if (bus.Mdu_done) begin
          pcWrite    = 1'b1;
          ifIdWrite  = 1'b1;
          controlSel = 1'b0;
          stateD     = RUN;
        end else if (cntQ == CNT_LAST) begin
          ifIdFlush = 1'b1;
          abortD    = 1'b1;
          timeoutD  = 1'b1;
          stateD    = RUN;
        end
      end

      default: begin
        stateD = RUN;
      end
    endcase

    if (!reset) begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      controlSel = 1'b0;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;
    end
  end

  // Sequencer state, watchdog and registered MDU handshake pulses. Reset
  // returns straight to RUN without an abort; the MDU shares the reset line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= RUN;
      cntQ     <= '0;
      startQ   <= 1'b0;
      abortQ   <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      startQ   <= startD;
      abortQ   <= abortD;
      timeoutQ <= timeoutD;
    end
  end

  assign bus.PC_write    = pcWrite;
  assign bus.IF_ID_Write = ifIdWrite;
  assign bus.Control_sel = controlSel;
  assign bus.IF_ID_Flush = ifIdFlush;
  assign bus.ID_EX_Flush = idExFlush;
  assign bus.Mdu_start   = startQ;
  assign bus.Mdu_abort   = abortQ;
  assign bus.Mdu_timeout = timeoutQ;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCntQ;
  logic [31:0] flushCntQ;

  // Saturating performance counters: frozen-PC cycles and IF/ID flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (!pcWrite && (stallCntQ != '1)) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if (ifIdFlush && (flushCntQ != '1)) begin
        flushCntQ <= flushCntQ + 32'd1;
      end
    end
  end

  assign bus.Stall_cycles = stallCntQ;
  assign bus.Flush_count  = flushCntQ;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Two instances share clock and reset:
// dut (MDU_TIMEOUT=40) for hazard/branch/MDU-handshake sequences and dutT
// (MDU_TIMEOUT=4) for the watchdog and mid-wait reset sequences.
// Control bundle order used in checks: {PC_write, IF_ID_Write, Control_sel,
// IF_ID_Flush, ID_EX_Flush}.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [4:0] IDLE   = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00100;
  localparam logic [4:0] BRANCH = 5'b11111;
  localparam logic [4:0] TMO    = 5'b00110;

  // Free-running pipeline clock, 10 ns period.
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_W(5)) bus ();
  pipeline_ctrl_if #(.REG_ADDR_W(5)) busT ();

  pipeline_ctrl #(
    .REG_ADDR_W  (5),
    .MDU_TIMEOUT (40),
    .CNT_W       (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipeline_ctrl #(
    .REG_ADDR_W  (5),
    .MDU_TIMEOUT (4),
    .CNT_W       (3)
  ) dutT (
    .clk   (clk),
    .reset (reset),
    .bus   (busT)
  );

  function automatic logic [31:0] ctrlMain();
    return {27'd0, bus.PC_write, bus.IF_ID_Write, bus.Control_sel,
            bus.IF_ID_Flush, bus.ID_EX_Flush};
  endfunction

  function automatic logic [31:0] ctrlT();
    return {27'd0, busT.PC_write, busT.IF_ID_Write, busT.Control_sel,
            busT.IF_ID_Flush, busT.ID_EX_Flush};
  endfunction

  // Single comparison point: counts every evaluation and every failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the main instance on the falling edge, settle, then return.
  task automatic applyStimulus(input logic mem, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic br, input logic op,
                               input logic done);
    @(negedge clk);
    bus.MemRead_EX      = mem;
    bus.RD_EX           = rd;
    bus.RS1_ID          = rs1;
    bus.RS2_ID          = rs2;
    bus.Branch_taken_EX = br;
    bus.Mdu_op_ID       = op;
    bus.Mdu_done        = done;
    #1;
  endtask

  // Drive the watchdog instance; only the MDU request varies there.
  task automatic applyStimulusT(input logic op);
    @(negedge clk);
    busT.MemRead_EX      = 1'b0;
    busT.RD_EX           = 5'd0;
    busT.RS1_ID          = 5'd0;
    busT.RS2_ID          = 5'd0;
    busT.Branch_taken_EX = 1'b0;
    busT.Mdu_op_ID       = op;
    busT.Mdu_done        = 1'b0;
    #1;
  endtask

  // Linear directed sequence.
  initial begin
    reset = 1'b1;
    bus.MemRead_EX = 1'b0;  bus.RD_EX = 5'd0;  bus.RS1_ID = 5'd0;  bus.RS2_ID = 5'd0;
    bus.Branch_taken_EX = 1'b0;  bus.Mdu_op_ID = 1'b0;  bus.Mdu_done = 1'b0;
    busT.MemRead_EX = 1'b0; busT.RD_EX = 5'd0; busT.RS1_ID = 5'd0; busT.RS2_ID = 5'd0;
    busT.Branch_taken_EX = 1'b0; busT.Mdu_op_ID = 1'b0; busT.Mdu_done = 1'b0;

    #2 reset = 1'b0;
    #1;
    checkOutput("rst_ctrl",    ctrlMain(), 32'(IDLE));
    checkOutput("rst_start",   32'(bus.Mdu_start), 32'd0);
    checkOutput("rst_abort",   32'(bus.Mdu_abort), 32'd0);
    checkOutput("rst_timeout", 32'(bus.Mdu_timeout), 32'd0);
    checkOutput("rstT_ctrl",   ctrlT(), 32'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("[TB] load-use sequences");
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_stall", ctrlMain(), 32'(STALL));
    applyStimulus(1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs1_release", ctrlMain(), 32'(IDLE));
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0_nostall", ctrlMain(), 32'(IDLE));
    applyStimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_stall", ctrlMain(), 32'(STALL));
    applyStimulus(1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("nonload_nostall", ctrlMain(), 32'(IDLE));

    $display("[TB] branch beats load-use and MDU request");
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("br_lu_flush", ctrlMain(), 32'(BRANCH));
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_no_start", 32'(bus.Mdu_start), 32'd0);
    checkOutput("br_stay_run", ctrlMain(), 32'(IDLE));

    $display("[TB] Mdu_done in RUN is ignored");
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("done_run_ctrl", ctrlMain(), 32'(IDLE));
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_run_start", 32'(bus.Mdu_start), 32'd0);

    $display("[TB] MDU normal completion on 10th wait cycle");
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("mdu_req_stall", ctrlMain(), 32'(STALL));
    checkOutput("mdu_req_nostart", 32'(bus.Mdu_start), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("mdu_w1_start", 32'(bus.Mdu_start), 32'd1);
    checkOutput("mdu_w1_stall", ctrlMain(), 32'(STALL));
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("mdu_w%0d_stall", i), ctrlMain(), 32'(STALL));
    end
    checkOutput("mdu_start_pulse", 32'(bus.Mdu_start), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("mdu_w10_issue", ctrlMain(), 32'(IDLE));
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mdu_back_run", ctrlMain(), 32'(IDLE));
    checkOutput("mdu_no_abort", 32'(bus.Mdu_abort), 32'd0);
    checkOutput("mdu_no_timeout", 32'(bus.Mdu_timeout), 32'd0);

    $display("[TB] branch in MDU_WAIT with simultaneous done");
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("wbr_w1_stall", ctrlMain(), 32'(STALL));
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("wbr_flush", {29'd0, bus.PC_write, bus.IF_ID_Flush, bus.ID_EX_Flush}, 32'b111);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wbr_abort", 32'(bus.Mdu_abort), 32'd1);
    checkOutput("wbr_run", ctrlMain(), 32'(IDLE));
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wbr_abort_pulse", 32'(bus.Mdu_abort), 32'd0);

    $display("[TB] watchdog timeout with MDU_TIMEOUT=4");
    applyStimulusT(1'b1);
    checkOutput("tmo_req_stall", ctrlT(), 32'(STALL));
    for (int i = 1; i <= 3; i++) begin
      applyStimulusT(1'b1);
      checkOutput($sformatf("tmo_w%0d_stall", i), ctrlT(), 32'(STALL));
    end
    applyStimulusT(1'b1);
    checkOutput("tmo_w4_flush", ctrlT(), 32'(TMO));
    checkOutput("tmo_w4_noabort", 32'(busT.Mdu_abort), 32'd0);
    checkOutput("tmo_w4_noflag", 32'(busT.Mdu_timeout), 32'd0);
    applyStimulusT(1'b0);
    checkOutput("tmo_abort", 32'(busT.Mdu_abort), 32'd1);
    checkOutput("tmo_flag", 32'(busT.Mdu_timeout), 32'd1);
    checkOutput("tmo_release", ctrlT(), 32'(IDLE));
    applyStimulusT(1'b0);
    checkOutput("tmo_abort_pulse", 32'(busT.Mdu_abort), 32'd0);
    checkOutput("tmo_flag_sticky", 32'(busT.Mdu_timeout), 32'd1);

    $display("[TB] asynchronous reset in MDU_WAIT");
    applyStimulusT(1'b1);
    applyStimulusT(1'b1);
    checkOutput("ar_w1_start", 32'(busT.Mdu_start), 32'd1);
    checkOutput("ar_w1_stall", ctrlT(), 32'(STALL));
    #3 reset = 1'b0;
    #1;
    checkOutput("ar_start_clr", 32'(busT.Mdu_start), 32'd0);
    checkOutput("ar_flag_clr", 32'(busT.Mdu_timeout), 32'd0);
    checkOutput("ar_no_abort", 32'(busT.Mdu_abort), 32'd0);
    checkOutput("ar_ctrl_idle", ctrlT(), 32'(IDLE));
    busT.Mdu_op_ID = 1'b0;
    #2 reset = 1'b1;
    applyStimulusT(1'b0);
    checkOutput("ar_run_ctrl", ctrlT(), 32'(IDLE));
    checkOutput("ar_run_abort", 32'(busT.Mdu_abort), 32'd0);
    checkOutput("ar_run_start", 32'(busT.Mdu_start), 32'd0);
    checkOutput("ar_run_flag", 32'(busT.Mdu_timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
